// File: rtl/cva6_axi_resp_monitor.sv
// cva6_axi_resp_monitor
// Passive AXI response-error monitor on the CVA6 cluster master link. It
// records the request address per ID, counts errored read bursts and errored
// write responses (saturating), and holds the first errored transaction sticky
// with a level interrupt until clear_i. It never drives the bus.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   ar_* / aw_*                request channel taps (id, addr sampled on valid&&ready)
//   r_*  / b_*                 response channel taps (id, resp, last)
//   clear_i                    single-cycle clear of counters and capture
//   rd_err_cnt_o, wr_err_cnt_o saturating error counters
//   err_valid_o, err_is_write_o, err_id_o, err_addr_o, err_resp_o  capture
//   irq_o                      level interrupt, mirrors err_valid_o
module cva6_axi_resp_monitor #(
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ar_valid_i,
  input  logic                 ar_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic                 aw_valid_i,
  input  logic                 aw_ready_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  input  logic [IdWidth-1:0]   r_id_i,
  input  logic [1:0]           r_resp_i,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   b_id_i,
  input  logic [1:0]           b_resp_i,
  input  logic                 clear_i,
  output logic [CntWidth-1:0]  rd_err_cnt_o,
  output logic [CntWidth-1:0]  wr_err_cnt_o,
  output logic                 err_valid_o,
  output logic                 err_is_write_o,
  output logic [IdWidth-1:0]   err_id_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [1:0]           err_resp_o,
  output logic                 irq_o
);

  localparam int unsigned NumIds = 1 << IdWidth;
  localparam logic [CntWidth-1:0] CntMax = '1;

  // Address tables and per-ID read-burst error flags
  logic [AddrWidth-1:0] rd_addr_q [NumIds];
  logic [AddrWidth-1:0] wr_addr_q [NumIds];
  logic [NumIds-1:0]    rd_err_q, rd_err_d;

  logic [CntWidth-1:0]  rd_cnt_q, rd_cnt_d, rd_cnt_base;
  logic [CntWidth-1:0]  wr_cnt_q, wr_cnt_d, wr_cnt_base;
  logic                 err_valid_q, err_valid_d, valid_base;
  logic                 err_is_write_q, err_is_write_d;
  logic [IdWidth-1:0]   err_id_q, err_id_d;
  logic [AddrWidth-1:0] err_addr_q, err_addr_d;
  logic [1:0]           err_resp_q, err_resp_d;

  logic ar_hs, aw_hs, r_hs, b_hs;
  logic r_err, b_err, rd_burst_err;

  // Handshake and error qualification; SLVERR/DECERR both have resp[1] set
  assign ar_hs        = ar_valid_i & ar_ready_i;
  assign aw_hs        = aw_valid_i & aw_ready_i;
  assign r_hs         = r_valid_i & r_ready_i;
  assign b_hs         = b_valid_i & b_ready_i;
  assign r_err        = r_hs & r_resp_i[1];
  assign b_err        = b_hs & b_resp_i[1];
  assign rd_burst_err = r_hs & r_last_i & (r_resp_i[1] | rd_err_q[r_id_i]);

  // Next-state: burst flags, counters (clear applied before increment), capture
  always_comb begin
    rd_err_d       = rd_err_q;
    rd_cnt_base    = clear_i ? '0 : rd_cnt_q;
    wr_cnt_base    = clear_i ? '0 : wr_cnt_q;
    rd_cnt_d       = rd_cnt_base;
    wr_cnt_d       = wr_cnt_base;
    valid_base     = err_valid_q & ~clear_i;
    err_valid_d    = valid_base;
    err_is_write_d = err_is_write_q;
    err_id_d       = err_id_q;
    err_addr_d     = err_addr_q;
    err_resp_d     = err_resp_q;

    if (r_err) begin
      rd_err_d[r_id_i] = 1'b1;
    end
    // Last beat closes the burst whatever its outcome
    if (r_hs && r_last_i) begin
      rd_err_d[r_id_i] = 1'b0;
    end

    if (rd_burst_err && (rd_cnt_base != CntMax)) begin
      rd_cnt_d = rd_cnt_base + CntWidth'(1);
    end
    if (b_err && (wr_cnt_base != CntMax)) begin
      wr_cnt_d = wr_cnt_base + CntWidth'(1);
    end

    // Read wins a same-cycle tie; table reads use pre-update entries
    if (!valid_base) begin
      if (r_err) begin
        err_valid_d    = 1'b1;
        err_is_write_d = 1'b0;
        err_id_d       = r_id_i;
        err_addr_d     = rd_addr_q[r_id_i];
        err_resp_d     = r_resp_i;
      end else if (b_err) begin
        err_valid_d    = 1'b1;
        err_is_write_d = 1'b1;
        err_id_d       = b_id_i;
        err_addr_d     = wr_addr_q[b_id_i];
        err_resp_d     = b_resp_i;
      end
    end
  end

  // Request address tables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        rd_addr_q[i] <= '0;
        wr_addr_q[i] <= '0;
      end
    end else begin
      if (ar_hs) rd_addr_q[ar_id_i] <= ar_addr_i;
      if (aw_hs) wr_addr_q[aw_id_i] <= aw_addr_i;
    end
  end

  // Status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_err_q       <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      err_valid_q    <= 1'b0;
      err_is_write_q <= 1'b0;
      err_id_q       <= '0;
      err_addr_q     <= '0;
      err_resp_q     <= '0;
    end else begin
      rd_err_q       <= rd_err_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      err_valid_q    <= err_valid_d;
      err_is_write_q <= err_is_write_d;
      err_id_q       <= err_id_d;
      err_addr_q     <= err_addr_d;
      err_resp_q     <= err_resp_d;
    end
  end

  assign rd_err_cnt_o   = rd_cnt_q;
  assign wr_err_cnt_o   = wr_cnt_q;
  assign err_valid_o    = err_valid_q;
  assign err_is_write_o = err_is_write_q;
  assign err_id_o       = err_id_q;
  assign err_addr_o     = err_addr_q;
  assign err_resp_o     = err_resp_q;
  assign irq_o          = err_valid_q;

endmodule

// File: tb/tb_cva6_axi_resp_monitor.sv
// Directed bench for cva6_axi_resp_monitor; a second instance with 4-bit
// counters shares the stimulus to exercise saturation.
module tb_cva6_axi_resp_monitor;

  localparam int unsigned IdW = 5;
  localparam int unsigned AW  = 64;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic ar_valid_i, ar_ready_i, aw_valid_i, aw_ready_i;
  logic [IdW-1:0] ar_id_i, aw_id_i, r_id_i, b_id_i;
  logic [AW-1:0]  ar_addr_i, aw_addr_i;
  logic r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i, clear_i;
  logic [1:0] r_resp_i, b_resp_i;

  logic [15:0] rd_cnt, wr_cnt;
  logic err_valid, err_is_write, irq;
  logic [IdW-1:0] err_id;
  logic [AW-1:0] err_addr;
  logic [1:0] err_resp;

  logic [3:0] rd_cnt4, wr_cnt4;
  logic err_valid4, err_is_write4, irq4;
  logic [IdW-1:0] err_id4;
  logic [AW-1:0] err_addr4;
  logic [1:0] err_resp4;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cva6_axi_resp_monitor dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
    .r_resp_i(r_resp_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
    .clear_i(clear_i),
    .rd_err_cnt_o(rd_cnt), .wr_err_cnt_o(wr_cnt), .err_valid_o(err_valid),
    .err_is_write_o(err_is_write), .err_id_o(err_id), .err_addr_o(err_addr),
    .err_resp_o(err_resp), .irq_o(irq)
  );

  cva6_axi_resp_monitor #(.CntWidth(4)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
    .r_resp_i(r_resp_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
    .clear_i(clear_i),
    .rd_err_cnt_o(rd_cnt4), .wr_err_cnt_o(wr_cnt4), .err_valid_o(err_valid4),
    .err_is_write_o(err_is_write4), .err_id_o(err_id4), .err_addr_o(err_addr4),
    .err_resp_o(err_resp4), .irq_o(irq4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ar_valid_i = 0; aw_valid_i = 0; r_valid_i = 0; b_valid_i = 0;
    r_last_i = 0; clear_i = 0;
  endtask

  task automatic do_ar(input logic [IdW-1:0] id, input logic [AW-1:0] addr);
    ar_valid_i = 1; ar_id_i = id; ar_addr_i = addr;
    tick(); idle();
  endtask

  task automatic do_aw(input logic [IdW-1:0] id, input logic [AW-1:0] addr);
    aw_valid_i = 1; aw_id_i = id; aw_addr_i = addr;
    tick(); idle();
  endtask

  task automatic do_r(input logic [IdW-1:0] id, input logic [1:0] resp, input logic last);
    r_valid_i = 1; r_id_i = id; r_resp_i = resp; r_last_i = last;
    tick(); idle();
  endtask

  task automatic do_b(input logic [IdW-1:0] id, input logic [1:0] resp);
    b_valid_i = 1; b_id_i = id; b_resp_i = resp;
    tick(); idle();
  endtask

  task automatic do_clear();
    clear_i = 1;
    tick(); idle();
  endtask

  initial begin
    rst_ni = 0;
    ar_ready_i = 1; aw_ready_i = 1; r_ready_i = 1; b_ready_i = 1;
    ar_id_i = '0; aw_id_i = '0; r_id_i = '0; b_id_i = '0;
    ar_addr_i = '0; aw_addr_i = '0; r_resp_i = 2'b00; b_resp_i = 2'b00;
    idle();
    #2;
    check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    tick(); tick();
    rst_ni = 1;
    tick();

    // 4-beat read on id 3, beat 1 SLVERR
    do_ar(5'd3, 64'h8000_1000);
    do_r(5'd3, 2'b00, 0);
    check("r_ok_no_capture", 64'(err_valid), 64'd0);
    do_r(5'd3, 2'b10, 0);
    check("t1_valid", 64'(err_valid), 64'd1);
    check("t1_irq", 64'(irq), 64'd1);
    check("t1_id", 64'(err_id), 64'd3);
    check("t1_addr", err_addr, 64'h8000_1000);
    check("t1_resp", 64'(err_resp), 64'd2);
    check("t1_is_write", 64'(err_is_write), 64'd0);
    check("t1_cnt_midburst", 64'(rd_cnt), 64'd0);
    do_r(5'd3, 2'b00, 0);
    do_r(5'd3, 2'b00, 1);
    check("t1_rd_cnt", 64'(rd_cnt), 64'd1);

    // Errored beat without ready is ignored
    r_valid_i = 1; r_ready_i = 0; r_id_i = 5'd3; r_resp_i = 2'b11; r_last_i = 1;
    tick(); idle(); r_ready_i = 1;
    check("no_ready_rd_cnt", 64'(rd_cnt), 64'd1);

    // Clear, then write error
    do_clear();
    check("clr_rd_cnt", 64'(rd_cnt), 64'd0);
    check("clr_valid", 64'(err_valid), 64'd0);
    check("clr_irq", 64'(irq), 64'd0);
    do_aw(5'd7, 64'h1_0000_0040);
    do_b(5'd7, 2'b11);
    check("t2_wr_cnt", 64'(wr_cnt), 64'd1);
    check("t2_valid", 64'(err_valid), 64'd1);
    check("t2_is_write", 64'(err_is_write), 64'd1);
    check("t2_id", 64'(err_id), 64'd7);
    check("t2_addr", err_addr, 64'h1_0000_0040);
    check("t2_resp", 64'(err_resp), 64'd3);
    check("t2_irq", 64'(irq), 64'd1);

    // Same-cycle read and write errors: read wins capture
    do_clear();
    ar_valid_i = 1; ar_id_i = 5'd1; ar_addr_i = 64'hA000_0100;
    aw_valid_i = 1; aw_id_i = 5'd2; aw_addr_i = 64'hB000_0200;
    tick(); idle();
    r_valid_i = 1; r_id_i = 5'd1; r_resp_i = 2'b10; r_last_i = 1;
    b_valid_i = 1; b_id_i = 5'd2; b_resp_i = 2'b10;
    tick(); idle();
    check("t3_id", 64'(err_id), 64'd1);
    check("t3_is_write", 64'(err_is_write), 64'd0);
    check("t3_addr", err_addr, 64'hA000_0100);
    check("t3_rd_cnt", 64'(rd_cnt), 64'd1);
    check("t3_wr_cnt", 64'(wr_cnt), 64'd1);

    // Build counters to 5/9, capture must stay on the first error
    for (int i = 0; i < 4; i++) do_r(5'd6, 2'b11, 1);
    for (int i = 0; i < 8; i++) do_b(5'd8, 2'b10);
    check("t4_rd_5", 64'(rd_cnt), 64'd5);
    check("t4_wr_9", 64'(wr_cnt), 64'd9);
    check("t4_capture_kept", 64'(err_id), 64'd1);

    // Clear coincident with a B DECERR
    do_aw(5'd9, 64'hC000_0900);
    clear_i = 1; b_valid_i = 1; b_id_i = 5'd9; b_resp_i = 2'b11;
    tick(); idle();
    check("t4_rd_cleared", 64'(rd_cnt), 64'd0);
    check("t4_wr_after_clr", 64'(wr_cnt), 64'd1);
    check("t4_valid", 64'(err_valid), 64'd1);
    check("t4_is_write", 64'(err_is_write), 64'd1);
    check("t4_id", 64'(err_id), 64'd9);
    check("t4_addr", err_addr, 64'hC000_0900);

    // Clear with a non-final errored beat: captured, not counted
    clear_i = 1; r_valid_i = 1; r_id_i = 5'd3; r_resp_i = 2'b10; r_last_i = 0;
    tick(); idle();
    check("clr_beat_rd_cnt", 64'(rd_cnt), 64'd0);
    check("clr_beat_wr_cnt", 64'(wr_cnt), 64'd0);
    check("clr_beat_valid", 64'(err_valid), 64'd1);
    check("clr_beat_id", 64'(err_id), 64'd3);
    do_r(5'd3, 2'b00, 1);
    check("clr_beat_burst_cnt", 64'(rd_cnt), 64'd1);

    // Same-cycle AR reusing the response ID: pre-update address captured
    do_clear();
    do_ar(5'd5, 64'h1111_0000);
    ar_valid_i = 1; ar_id_i = 5'd5; ar_addr_i = 64'h2222_0000;
    r_valid_i = 1; r_id_i = 5'd5; r_resp_i = 2'b11; r_last_i = 1;
    tick(); idle();
    check("preupd_addr", err_addr, 64'h1111_0000);

    // Saturation: 20 B errors
    do_clear();
    for (int i = 0; i < 20; i++) do_b(5'd4, 2'b11);
    check("sat4_wr", 64'(wr_cnt4), 64'd15);
    check("sat16_wr", 64'(wr_cnt), 64'd20);

    // Interleaved bursts on ids 0 and 4
    do_clear();
    do_ar(5'd0, 64'h0000_0A00);
    do_ar(5'd4, 64'h0000_0B00);
    do_r(5'd0, 2'b00, 0);
    do_r(5'd4, 2'b00, 0);
    do_r(5'd0, 2'b10, 0);
    do_r(5'd4, 2'b00, 0);
    do_r(5'd0, 2'b00, 1);
    check("il_rd_cnt_a", 64'(rd_cnt), 64'd1);
    do_r(5'd4, 2'b00, 1);
    check("il_rd_cnt", 64'(rd_cnt), 64'd1);
    check("il_addr", err_addr, 64'h0000_0A00);

    // Reset mid-burst with id 0 flagged
    do_ar(5'd0, 64'h0000_0C00);
    do_r(5'd0, 2'b11, 0);
    #2 rst_ni = 0;
    #1;
    check("arst_rd_cnt", 64'(rd_cnt), 64'd0);
    check("arst_wr_cnt", 64'(wr_cnt), 64'd0);
    check("arst_valid", 64'(err_valid), 64'd0);
    check("arst_irq", 64'(irq), 64'd0);
    tick();
    rst_ni = 1;
    tick();
    do_r(5'd0, 2'b00, 1);
    check("trail_rd_cnt", 64'(rd_cnt), 64'd0);
    check("trail_valid", 64'(err_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
